// File: rtl/in_port_buffer_if.sv
// Device/control-unit side signals of the buffered input port.
// slave: the buffer itself; master: the device and control unit driving it.
interface in_port_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] dev_data;
  logic              dev_valid;
  logic              dev_ready;
  logic              PortInout;
  logic [DATA_W-1:0] BusMuxIn_InPort;
  logic              in_avail;
  logic [PTR_W:0]    in_count;
  logic              underflow;

  modport slave (
    input  dev_data, dev_valid, PortInout,
    output dev_ready, BusMuxIn_InPort, in_avail, in_count, underflow
  );

  modport master (
    output dev_data, dev_valid, PortInout,
    input  dev_ready, BusMuxIn_InPort, in_avail, in_count, underflow
  );
endinterface

// File: rtl/in_port_buffer.sv
// Buffered input port: device words queue in a small FIFO, popped by the `in` read strobe.
// Define INPORT_EDGE_POP_EN to pop once per rising edge of PortInout instead of per high cycle.
module in_port_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic            clock,
  input  logic            clear,
  in_port_buffer_if.slave bus
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [DATA_W-1:0] r_last_word;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop_req;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.dev_valid && !w_full;
  assign w_pop   = w_pop_req && !w_empty;

`ifdef INPORT_EDGE_POP_EN
  logic r_port_d;

  // Delayed strobe for rising-edge detection
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_port_d <= 1'b0;
    end else begin
      r_port_d <= bus.PortInout;
    end
  end

  assign w_pop_req = bus.PortInout && !r_port_d;
`else
  assign w_pop_req = bus.PortInout;
`endif

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.dev_data;
    end
  end

  // Pointers, occupancy, last popped word and sticky underflow
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_word <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_last_word <= r_mem[r_rd_ptr];
      end
      if (w_pop_req && w_empty) begin
        r_underflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Last popped word stays on the bus once drained so a late read sees stable data
  assign bus.BusMuxIn_InPort = w_empty ? r_last_word : r_mem[r_rd_ptr];
  assign bus.dev_ready       = !w_full;
  assign bus.in_avail        = !w_empty;
  assign bus.in_count        = r_count;
  assign bus.underflow       = r_underflow;
endmodule

// File: tb/tb_in_port_buffer.sv
// Directed self-checking bench for in_port_buffer (DEPTH=4, DATA_W=32).
module tb_in_port_buffer;
  logic clk;
  logic clear;
  int   n_vec;
  int   n_fail;

  in_port_buffer_if #(.DATA_W(32), .DEPTH(4)) bus ();

  in_port_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] data, input logic [2:0] cnt,
                           input logic rdy, input logic avail, input logic uf);
    chk({tag, ".data"}, bus.BusMuxIn_InPort, data);
    chk({tag, ".count"}, 32'(bus.in_count), 32'(cnt));
    chk({tag, ".ready"}, 32'(bus.dev_ready), 32'(rdy));
    chk({tag, ".avail"}, 32'(bus.in_avail), 32'(avail));
    chk({tag, ".uflow"}, 32'(bus.underflow), 32'(uf));
  endtask

  task automatic push(input logic [31:0] w);
    bus.dev_data  = w;
    bus.dev_valid = 1'b1;
    tick();
    bus.dev_valid = 1'b0;
  endtask

  // one-cycle strobe followed by a low cycle so edge mode sees a fresh rising edge
  task automatic strobe();
    bus.PortInout = 1'b1;
    tick();
    bus.PortInout = 1'b0;
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    clear         = 1'b0;
    bus.dev_data  = 32'h0;
    bus.dev_valid = 1'b0;
    bus.PortInout = 1'b0;
    #3;
    chk_state("reset", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    tick();

    // ordering
    push(32'h11);
    chk_state("push1", 32'h11, 3'd1, 1'b1, 1'b1, 1'b0);
    push(32'h22);
    push(32'h33);
    chk_state("push3", 32'h11, 3'd3, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("pop1", 32'h22, 3'd2, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("pop2", 32'h33, 3'd1, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("pop3", 32'h33, 3'd0, 1'b1, 1'b0, 1'b0);

    // full, with pointers starting at 3 so both wrap
    push(32'hA1);
    push(32'hA2);
    push(32'hA3);
    chk_state("fill3", 32'hA1, 3'd3, 1'b1, 1'b1, 1'b0);
    push(32'hA4);
    chk_state("full", 32'hA1, 3'd4, 1'b0, 1'b1, 1'b0);
    bus.dev_data  = 32'hEE;
    bus.dev_valid = 1'b1;
    tick();
    chk_state("full_hold", 32'hA1, 3'd4, 1'b0, 1'b1, 1'b0);
    bus.PortInout = 1'b1;
    tick();
    chk_state("full_pop", 32'hA2, 3'd3, 1'b1, 1'b1, 1'b0);
    bus.PortInout = 1'b0;
    tick();
    bus.dev_valid = 1'b0;
    chk_state("full_accept", 32'hA2, 3'd4, 1'b0, 1'b1, 1'b0);
    strobe();
    chk_state("drain1", 32'hA3, 3'd3, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("drain2", 32'hA4, 3'd2, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("drain3", 32'hEE, 3'd1, 1'b1, 1'b1, 1'b0);
    strobe();
    chk_state("drain4", 32'hEE, 3'd0, 1'b1, 1'b0, 1'b0);

    // underflow is sticky
    strobe();
    chk_state("uflow", 32'hEE, 3'd0, 1'b1, 1'b0, 1'b1);
    push(32'h44);
    chk_state("uflow_push", 32'h44, 3'd1, 1'b1, 1'b1, 1'b1);
    strobe();
    chk_state("uflow_pop", 32'h44, 3'd0, 1'b1, 1'b0, 1'b1);

    // push and pop together at count 2
    push(32'h61);
    push(32'h62);
    chk_state("conc_pre", 32'h61, 3'd2, 1'b1, 1'b1, 1'b1);
    bus.dev_data  = 32'h55;
    bus.dev_valid = 1'b1;
    bus.PortInout = 1'b1;
    tick();
    bus.dev_valid = 1'b0;
    bus.PortInout = 1'b0;
    chk_state("conc", 32'h62, 3'd2, 1'b1, 1'b1, 1'b1);
    tick();

    // asynchronous clear mid-cycle discards buffered words
    #2;
    clear = 1'b0;
    #1;
    chk_state("clear_async", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    tick();

    // strobe held for three cycles with two words queued
    push(32'h71);
    push(32'h72);
    bus.PortInout = 1'b1;
    tick();
    tick();
    tick();
    bus.PortInout = 1'b0;
    tick();
`ifdef INPORT_EDGE_POP_EN
    chk_state("held_edge", 32'h72, 3'd1, 1'b1, 1'b1, 1'b0);
`else
    chk_state("held_level", 32'h72, 3'd0, 1'b1, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
